prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 12'h000: first program-memory address written in each load session.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  level-sampled request to begin a load session.
REQ-005 length  input  12  byte count of the session, sampled on session start; 12'h000 means 4096 bytes.
REQ-006 nib_valid  input  1  source presents a nibble on nib_data.
REQ-007 nib_data  input  4  nibble from the source; the high nibble of each byte comes first.
REQ-008 nib_ready  output  1  loader accepts a nibble this cycle; a transfer occurs when nib_valid and nib_ready are both 1.
REQ-009 mem_we  output  1  one-cycle write strobe to program memory.
REQ-010 mem_addr  output  12  program-memory write address.
REQ-011 mem_wdata  output  8  program byte {high nibble, low nibble}, the same layout the fetch stage splits into instr/oprnd.
REQ-012 cpu_hold  output  1  holds the processor in reset while a session is active.
REQ-013 busy  output  1  a session is in progress.
REQ-014 done  output  1  the last session completed.
REQ-015 chk_err  output  1  checksum mismatch on the last session (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, HI, LO, WRITE, CHK_HI, CHK_LO and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL:
- latch length into the byte counter;
- set the address to BASE_ADDR;
- clear done and chk_err;
- move to HI on the next edge.
REQ-018 start SHALL be ignored in every other state.
REQ-019 nib_ready SHALL be 1 only in HI, LO, CHK_HI and CHK_LO.
REQ-020 nib_ready SHALL not depend combinationally on nib_valid.
REQ-021 A transfer in HI SHALL store the high nibble and move to LO.
REQ-022 A transfer in LO SHALL store the low nibble and move to WRITE.
REQ-023 With no transfer, the FSM SHALL hold its state indefinitely.
REQ-024 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr and mem_wdata stable in that cycle.
REQ-025 mem_we SHALL be 0 in every other state.
REQ-026 Latency from the low-nibble transfer edge to mem_we high SHALL be 1 cycle.
REQ-027 nib_ready SHALL be 0 during WRITE, so a byte takes at least 3 cycles.
REQ-028 On leaving WRITE, the address SHALL increment by 1, modulo 4096 (12'hFFF wraps to 12'h000).
REQ-029 On leaving WRITE, the byte counter SHALL decrement by 1.
REQ-030 When the byte just written is the last one, WRITE SHALL move to CHK_HI if CHECKSUM_EN is defined, else to DONE.
REQ-031 Otherwise, WRITE SHALL move to HI.
REQ-032 CHK_HI and CHK_LO SHALL accept the two checksum nibbles and then move to DONE.
REQ-033 CHK_HI and CHK_LO SHALL never assert mem_we.
REQ-034 busy and cpu_hold SHALL be 1 in HI, LO, WRITE, CHK_HI and CHK_LO.
REQ-035 busy and cpu_hold SHALL be 0 in IDLE and DONE.
REQ-036 done SHALL be 1 only in DONE.
REQ-037 DONE SHALL persist until a new start or reset.
REQ-038 With length=12'h000, the session SHALL write 4096 bytes, covering every address exactly once.

Reset
REQ-039 With reset=0 at a clock edge, the FSM SHALL enter IDLE, and these outputs SHALL be 0: nib_ready, mem_we, cpu_hold, busy, done, chk_err.
REQ-040 With reset=0 at a clock edge, the address SHALL be set to BASE_ADDR and the byte counter to 0.
REQ-041 Reset asserted mid-session SHALL abort the session, with no further write strobe; bytes already written remain.
REQ-042 reset SHALL take priority over start and over any nibble transfer in the same cycle.

Configuration
REQ-043 The macro PROG_LOADER_CHECKSUM_EN SHALL select the checksum feature.
REQ-044 With PROG_LOADER_CHECKSUM_EN defined:
- an 8-bit modulo-256 sum SHALL accumulate every written byte plus the trailing checksum byte;
- the sum SHALL clear on session start;
- on entry to DONE, chk_err SHALL be 1 if the sum is not 8'h00;
- chk_err SHALL hold until the next start or reset.
REQ-045 With PROG_LOADER_CHECKSUM_EN undefined:
- the CHK_HI and CHK_LO states are unreachable;
- WRITE of the last byte moves directly to DONE;
- the chk_err port remains present and tied to 0.

Verification
REQ-046 Reset, then start=1 with length=2, BASE_ADDR=0, nibbles 4,7,A,3 -> writes 8'h47 @12'h000 and 8'hA3 @12'h001; done=1; cpu_hold is 1 from the first HI state until DONE.
REQ-047 nib_valid dropped for 5 cycles between the high and low nibbles -> FSM holds in LO; exactly one mem_we follows the delayed low nibble; mem_wdata is correct.
REQ-048 BASE_ADDR=12'hFFF, length=2 -> writes go to 12'hFFF then 12'h000.
REQ-049 Reset driven to 0 one cycle after the first byte's low-nibble transfer (FSM in WRITE) -> no write strobe at or after the reset edge; IDLE; all outputs 0; a following start restarts at BASE_ADDR.
REQ-050 start pulsed while busy -> ignored; the byte count and address sequence are unaffected.
REQ-051 PROG_LOADER_CHECKSUM_EN defined, bytes 8'h10, 8'h20 with checksum 8'hD0 -> chk_err=0; same bytes with checksum 8'hD1 -> chk_err=1; neither checksum byte is written.

Source files
------------

// File: rtl/prog_loader.sv
// Nibble-serial program loader: assembles bytes and writes them to program memory, holding the CPU in reset.
// Latency: write strobe one cycle after the low-nibble transfer; each byte takes at least 3 cycles.
// Backpressure: nib_ready_o is a pure function of state; low in WRITE/IDLE/DONE. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [11:0] length_i,
    input  logic        nib_valid_i,
    input  logic [3:0]  nib_data_i,
    output logic        nib_ready_o,
    output logic        mem_we_o,
    output logic [11:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        chk_err_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HI     = 3'd1,
        LO     = 3'd2,
        WRITE  = 3'd3,
        CHK_HI = 3'd4,
        CHK_LO = 3'd5,
        DONE   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] addr_q, addr_d;
    logic [3:0]  hi_q, hi_d;
    logic [3:0]  lo_q, lo_d;
    logic        xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        chk_err_q, chk_err_d;
`endif

    always_comb begin
        nib_ready_o = (state_q == HI) || (state_q == LO) ||
                      (state_q == CHK_HI) || (state_q == CHK_LO);
        mem_we_o    = (state_q == WRITE);
        busy_o      = (state_q != IDLE) && (state_q != DONE);
        cpu_hold_o  = busy_o;
        done_o      = (state_q == DONE);
        mem_addr_o  = addr_q;
        mem_wdata_o = {hi_q, lo_q};
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_err_o   = chk_err_q;
`else
        chk_err_o   = 1'b0;
`endif
    end

    assign xfer = nib_valid_i && nib_ready_o;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    // length 0 counts down from 0 through 12'hFFF, giving 4096 bytes
                    cnt_d   = length_i;
                    addr_d  = BASE_ADDR;
                    state_d = HI;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d     = 8'h00;
                    chk_err_d = 1'b0;
`endif
                end
            end
            HI: begin
                if (xfer) begin
                    hi_d    = nib_data_i;
                    state_d = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    lo_d    = nib_data_i;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d = addr_q + 12'd1;
                cnt_d  = cnt_q - 12'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d  = sum_q + {hi_q, lo_q};
                state_d = (cnt_q == 12'd1) ? CHK_HI : HI;
`else
                state_d = (cnt_q == 12'd1) ? DONE : HI;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK_HI: begin
                if (xfer) begin
                    hi_d    = nib_data_i;
                    state_d = CHK_LO;
                end
            end
            CHK_LO: begin
                // the checksum byte is folded into the sum but never written to memory
                if (xfer) begin
                    sum_d     = sum_q + {hi_q, nib_data_i};
                    chk_err_d = (sum_d != 8'h00);
                    state_d   = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 12'd0;
            addr_q  <= BASE_ADDR;
            hi_q    <= 4'd0;
            lo_q    <= 4'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= 8'h00;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

endmodule
